// File: rtl/traffic_pkg.sv
// Shared types and default timing for the intersection scheduler and the
// per-approach traffic_light lamp drivers.
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_FLASH  = 3'd1,
    A_YELLOW = 3'd2,
    A_CLEAR  = 3'd3,
    B_GREEN  = 3'd4,
    B_FLASH  = 3'd5,
    B_YELLOW = 3'd6,
    B_CLEAR  = 3'd7
  } phase_e;

  typedef struct packed {
    logic r;
    logic g;
    logic y;
  } lamp_t;

  typedef struct packed {
    lamp_t a;
    lamp_t b;
  } heads_t;

  localparam int MIN_GREEN_DEF  = 128;
  localparam int MAX_GREEN_DEF  = 1024;
  localparam int YELLOW_LEN_DEF = 512;
  localparam int ALLRED_LEN_DEF = 64;
  localparam int FLASH_LEN_DEF  = 128;
  localparam int CNT_W_DEF      = 11;

  localparam lamp_t LAMP_RED = '{r: 1'b1, g: 1'b0, y: 1'b0};
  localparam lamp_t LAMP_GRN = '{r: 1'b0, g: 1'b1, y: 1'b0};
  localparam lamp_t LAMP_YEL = '{r: 1'b0, g: 1'b0, y: 1'b1};

  // Lamp pattern shown by both heads while in phase p; the idle head is always red.
  function automatic heads_t heads_for(phase_e p, logic flash_g);
    heads_t h;
    h.a = LAMP_RED;
    h.b = LAMP_RED;
    case (p)
      A_GREEN:  h.a = LAMP_GRN;
      A_FLASH:  h.a = '{r: 1'b0, g: flash_g, y: 1'b0};
      A_YELLOW: h.a = LAMP_YEL;
      B_GREEN:  h.b = LAMP_GRN;
      B_FLASH:  h.b = '{r: 1'b0, g: flash_g, y: 1'b0};
      B_YELLOW: h.b = LAMP_YEL;
      default:  ;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable phase counter: load restarts at 1, otherwise counts up and
// saturates at limit; done flags count == limit.
module phase_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= CNT_W'(1);
    end else if (load) begin
      r_count <= CNT_W'(1);
    end else if (r_count < limit) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;
  assign done  = (r_count == limit);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach green/yellow/all-red sequencer over a shared crossing.
// Optional flashing-green phase enabled by defining FLASH_GREEN_EN.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = MIN_GREEN_DEF,
  parameter int MAX_GREEN  = MAX_GREEN_DEF,
  parameter int YELLOW_LEN = YELLOW_LEN_DEF,
  parameter int ALLRED_LEN = ALLRED_LEN_DEF,
  parameter int FLASH_LEN  = FLASH_LEN_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       R_a,
  output logic       G_a,
  output logic       Y_a,
  output logic       R_b,
  output logic       G_b,
  output logic       Y_b,
  output logic [2:0] phase
);

  phase_e           r_state;
  heads_t           r_heads;
  logic             r_pend_a, r_pend_b;
  logic             r_ack_a, r_ack_b;

  phase_e           w_next;
  logic             w_legal;
  logic             w_load;
  logic             w_done;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] w_count;
  logic             w_min_met;
  logic             w_enter_a, w_enter_b;
  logic             w_serving_a, w_serving_b;
  logic             w_flash_g;

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .limit(w_limit),
    .count(w_count),
    .done (w_done)
  );

  assign w_min_met = (w_count >= CNT_W'(MIN_GREEN));

  // NOTE: every signal assigned in this block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_next  = r_state;
    w_limit = CNT_W'(MAX_GREEN);
    w_legal = 1'b1;
    case (r_state)
      A_GREEN: begin
        if (r_pend_b && w_min_met) begin
`ifdef FLASH_GREEN_EN
          w_next = A_FLASH;
`else
          w_next = A_YELLOW;
`endif
        end
      end
      B_GREEN: begin
        if (r_pend_a && w_min_met) begin
`ifdef FLASH_GREEN_EN
          w_next = B_FLASH;
`else
          w_next = B_YELLOW;
`endif
        end
      end
`ifdef FLASH_GREEN_EN
      A_FLASH: begin
        w_limit = CNT_W'(FLASH_LEN);
        if (w_done) w_next = A_YELLOW;
      end
      B_FLASH: begin
        w_limit = CNT_W'(FLASH_LEN);
        if (w_done) w_next = B_YELLOW;
      end
`endif
      A_YELLOW: begin
        w_limit = CNT_W'(YELLOW_LEN);
        if (w_done) w_next = A_CLEAR;
      end
      B_YELLOW: begin
        w_limit = CNT_W'(YELLOW_LEN);
        if (w_done) w_next = B_CLEAR;
      end
      A_CLEAR: begin
        w_limit = CNT_W'(ALLRED_LEN);
        if (w_done) w_next = B_GREEN;
      end
      B_CLEAR: begin
        w_limit = CNT_W'(ALLRED_LEN);
        if (w_done) w_next = A_GREEN;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_load      = (w_next != r_state) || !w_legal;
  assign w_enter_a   = (w_next == A_GREEN) && (r_state != A_GREEN);
  assign w_enter_b   = (w_next == B_GREEN) && (r_state != B_GREEN);
  assign w_serving_a = (r_state == A_GREEN) || (r_state == A_FLASH);
  assign w_serving_b = (r_state == B_GREEN) || (r_state == B_FLASH);

`ifdef FLASH_GREEN_EN
  // Lamp is registered for the next cycle, so bit 5 of the current count
  // selects the 32-cycle half-period; entry into FLASH always starts dark.
  assign w_flash_g = (w_next == r_state) && w_count[5];
`else
  assign w_flash_g = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst || !w_legal) begin
      r_state  <= A_GREEN;
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_heads  <= heads_for(A_GREEN, 1'b0);
    end else begin
      r_state  <= w_next;
      r_ack_a  <= w_enter_a;
      r_ack_b  <= w_enter_b;
      r_pend_a <= !w_enter_a && (r_pend_a || (req_a && !w_serving_a));
      r_pend_b <= !w_enter_b && (r_pend_b || (req_b && !w_serving_b));
      r_heads  <= heads_for(w_next, w_flash_g);
    end
  end

  assign ack_a = r_ack_a;
  assign ack_b = r_ack_b;
  assign R_a   = r_heads.a.r;
  assign G_a   = r_heads.a.g;
  assign Y_a   = r_heads.a.y;
  assign R_b   = r_heads.b.r;
  assign G_b   = r_heads.b.g;
  assign Y_b   = r_heads.b.y;
  assign phase = r_state;

endmodule
